// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words,
// writes them to memory, then verifies the contents by reading them back and comparing XOR checksums.
module instr_mem_loader #(
    parameter int DEPTH  = 18,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_VM,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [31:0]       dataout_VM,
    output logic [ADDR_W-1:0] address_VM,
    output logic [31:0]       datain_VM,
    output logic              mode_VM,
    output logic              is_instruction_stored,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_RD_ADDR, S_RD_CAP, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_n;
    logic [31:0]       shreg, wsum, rsum, data_q, rsum_upd;
    logic [1:0]        bidx;
    logic [ADDR_W-1:0] rp, nwords, addr_q, rp_inc, ww_inc;
    logic              idle_like, bad_n;

    always_ff @(posedge clock) begin
        if (reset_VM) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
        bad_n      = (num_words == '0) || (num_words > DEPTH_W);
        rsum_upd   = rsum ^ dataout_VM;
        rp_inc     = rp + 1'b1;
        ww_inc     = words_written + 1'b1;
        state_n    = state;
        byte_ready = (state == S_COLLECT);
        mode_VM    = (state == S_WRITE);
        busy       = !idle_like;
        address_VM = addr_q;
        datain_VM  = data_q;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) state_n = bad_n ? S_ERROR : S_COLLECT;
            S_COLLECT:
                if (byte_valid && bidx == 2'd3) state_n = S_WRITE;
            S_WRITE: begin
                address_VM = words_written;
                datain_VM  = shreg;
                state_n    = (ww_inc == nwords) ? S_RD_ADDR : S_COLLECT;
            end
            S_RD_ADDR: begin
                address_VM = rp;
                state_n    = S_RD_CAP;
            end
            S_RD_CAP:
                if (rp_inc == nwords) state_n = (rsum_upd == wsum) ? S_DONE : S_ERROR;
                else                  state_n = S_RD_ADDR;
            default: state_n = S_IDLE;
        endcase
    end

    // Memory address/data are registered copies so they hold their last driven value outside WRITE/RD_ADDR.
    always_ff @(posedge clock) begin
        if (reset_VM) begin
            shreg                 <= '0;
            wsum                  <= '0;
            rsum                  <= '0;
            data_q                <= '0;
            addr_q                <= '0;
            bidx                  <= '0;
            rp                    <= '0;
            nwords                <= '0;
            words_written         <= '0;
            is_instruction_stored <= 1'b0;
            error                 <= 1'b0;
            err_code              <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR:
                    if (start) begin
                        is_instruction_stored <= 1'b0;
                        if (bad_n) begin
                            error    <= 1'b1;
                            err_code <= 2'd1;
                        end else begin
                            error         <= 1'b0;
                            err_code      <= '0;
                            words_written <= '0;
                            bidx          <= '0;
                            wsum          <= '0;
                            rsum          <= '0;
                            nwords        <= num_words;
                        end
                    end
                S_COLLECT:
                    if (byte_valid) begin
                        shreg <= {shreg[23:0], byte_in};
                        bidx  <= bidx + 1'b1;
                    end
                S_WRITE: begin
                    wsum          <= wsum ^ shreg;
                    words_written <= ww_inc;
                    addr_q        <= words_written;
                    data_q        <= shreg;
                    rp            <= '0;
                end
                S_RD_ADDR:
                    addr_q <= rp;
                S_RD_CAP: begin
                    rsum <= rsum_upd;
                    rp   <= rp_inc;
                    if (rp_inc == nwords) begin
                        if (rsum_upd == wsum) begin
                            is_instruction_stored <= 1'b1;
                        end else begin
                            error    <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction-memory load interface. It takes a byte stream from a host or UART front-end, packs each 4 bytes into a 32-bit instruction, and writes the words one by one into the instruction memory through address_VM/datain_VM/mode_VM. It then reads back every word and checks it against an XOR checksum. Only after a clean check does it raise is_instruction_stored, which releases the core to fetch from PC 0.

Parameters:
DEPTH, 18, number of instruction-memory words; num_words must be 1..DEPTH
ADDR_W, 5, width of address_VM and of num_words

Ports:
clock  input  1  system clock; all logic on posedge
reset_VM  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latches num_words and begins a load
num_words  input  ADDR_W  number of words to load, sampled with start
byte_in  input  8  stream byte, big-endian: first byte is instr[31:24]
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts byte_in this cycle
dataout_VM  input  32  read data from memory; valid the cycle after a read address is driven
address_VM  output  ADDR_W  memory word address
datain_VM  output  32  memory write data
mode_VM  output  1  1 = write, 0 = read
is_instruction_stored  output  1  program loaded and verified; core may run
busy  output  1  high in every state except IDLE, DONE and ERROR
error  output  1  load failed; sticky until the next start or reset
err_code  output  2  0 = none, 1 = bad num_words, 2 = checksum mismatch
words_written  output  ADDR_W  count of words committed in this load

Behaviour:
- Reset (synchronous, active-high, reset_VM=1 at a posedge):
  - all outputs go to 0 and the state goes to IDLE.
  - Reset has priority over every other input, including a reset asserted mid-load.
  - The loader does not drive the memory's own reset.
- States: IDLE, COLLECT, WRITE, RD_ADDR, RD_CAP, DONE, ERROR.
- IDLE / DONE / ERROR, on start=1:
  - If num_words==0 or num_words>DEPTH: go to ERROR with err_code=1.
  - Otherwise: clear error, err_code, words_written, the byte index, the write checksum wsum and the read checksum rsum; drop is_instruction_stored to 0; go to COLLECT.
  - start is ignored in every other state.
- COLLECT:
  - byte_ready=1.
  - Each cycle with byte_valid=1 shifts byte_in into the low byte of the shift register (shreg = {shreg[23:0], byte_in}) and increments the byte index.
  - On the 4th byte, go to WRITE.
  - Gaps in byte_valid stall the loader without losing any state.
- WRITE (exactly one cycle):
  - Drive mode_VM=1, address_VM=words_written, datain_VM=shreg.
  - wsum ^= shreg; words_written += 1.
  - If words_written reaches num_words, set the read pointer rp=0 and go to RD_ADDR; otherwise return to COLLECT.
  - byte_ready=0 in this cycle.
- RD_ADDR: drive mode_VM=0, address_VM=rp; go to RD_CAP.
- RD_CAP:
  - rsum ^= dataout_VM; rp += 1.
  - If rp==num_words, go to DONE when rsum==wsum (using the updated rsum), or to ERROR with err_code=2 otherwise.
  - If not, return to RD_ADDR.
- DONE: is_instruction_stored=1, held until the next start or reset.
- mode_VM is 1 only in WRITE. In every other state it is 0, and address_VM/datain_VM hold their last values.
- byte_ready is 0 in every state except COLLECT. Bytes offered outside COLLECT are not consumed.
- Latency:
  - Minimum 5 cycles per word for collection plus write (4 byte beats + WRITE).
  - 2 cycles per word for readback.
  - DONE is reached 5N+2N cycles after start at the earliest, where N = num_words.
- Arithmetic: the XOR checksums are 32 bits wide; words_written and rp are ADDR_W bits wide and never exceed DEPTH.
- Only one load runs at a time. A start that arrives in the same cycle as a byte is handled as a start; the byte is not consumed.

Test Plan:
- Reset, then start with num_words=1 and bytes 23,FF,00,01 sent back to back -> exactly one WRITE cycle with mode_VM=1, address_VM=0, datain_VM=0x23FF0001; then one readback of address 0; is_instruction_stored=1 at cycle 7 after start.
- Full 18-word bubble-sort program, with byte_valid deasserted randomly 1-3 cycles between bytes -> memory model holds all 18 words in order, words_written=18, error=0, is_instruction_stored=1.
- Memory model flips bit 0 of word 5 on readback (num_words=18) -> ERROR, err_code=2, is_instruction_stored stays 0; a new start followed by a clean load reaches DONE.
- start with num_words=0, then with 19 -> ERROR with err_code=1, no write cycles, byte_ready=0.
- reset_VM asserted after word 3 has been written and 2 bytes of word 4 accepted -> all outputs 0, state IDLE; a fresh load of 4 words writes addresses 0..3 with no leftover bytes.
- start pulsed during COLLECT, and bytes offered while in DONE -> both ignored; byte_ready=0 throughout DONE.
